pe_operand_sequencer: RTL and testbench
=======================================

Name: pe_operand_sequencer

Overview:
- Initiator for one processing_unit multiply-accumulate element.
- Buffers FP16 operand pairs, drives the element's start/a/b inputs one pair at a time and waits for its ready pulse.
- Captures each accumulated P and returns the final dot-product result over a valid/ready handshake.
- Sits between the operand loader and the element inside each array tile.

Parameters:
- DEPTH, 8, operand-pair FIFO entries (power of 2).
- LEN_W, 4, width of the job length field.
- TIMEOUT, 64, watchdog limit in cycles per pair (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- wr_en  in  1  push operand pair.
- wr_a  in  16  FP16 operand A.
- wr_b  in  16  FP16 operand B.
- full  out  1  FIFO full; a push while full is dropped.
- go  in  1  start job; sampled only in IDLE.
- len  in  LEN_W  number of pairs to accumulate.
- busy  out  1  high in every state except IDLE.
- pe_clear  out  1  one-cycle accumulator clear pulse, ORed into the element's reset at tile level.
- pe_start  out  1  operand valid and enable to the element.
- pe_a  out  16  operand A to the element.
- pe_b  out  16  operand B to the element.
- pe_ready  in  1  element result-valid pulse.
- pe_P  in  16  element accumulated sum.
- res_valid  out  1  result valid.
- res_data  out  16  final accumulated sum.
- res_ready  in  1  downstream accept.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0. Reset mid-job aborts the job and discards FIFO contents.
- FIFO: DEPTH x 32 bits ({a,b}). Pointers wrap modulo DEPTH. Count tracks occupancy 0..DEPTH.
- Push and pop in the same cycle while full: both succeed and count is unchanged.
- A push while full with no pop is dropped and count is unchanged.
- IDLE:
  - go=1 and len!=0: latch len into remaining, pulse pe_clear for 1 cycle, go to ISSUE.
  - go=1 and len=0: go to DONE with res_data=0.
- ISSUE:
  - FIFO empty: pe_start stays 0 and the state holds (stall).
  - FIFO not empty: pop the head into pe_a/pe_b, set pe_start=1, go to WAIT.
- WAIT:
  - pe_start=1; pe_a/pe_b held stable.
  - On pe_ready=1: capture pe_P into res_data, decrement remaining, set pe_start=0.
  - Then remaining==0 -> DONE; otherwise -> GAP.
- GAP: exactly 1 cycle with pe_start=0, so the element restarts its internal counters; then ISSUE.
- Minimum spacing between pe_start assertions is 2 cycles.
- DONE:
  - res_valid=1 with res_data held.
  - When res_valid and res_ready are both high: clear res_valid, go to IDLE. busy falls in the same cycle.
- A go asserted outside IDLE is ignored.
- Every pe_ready sampled in WAIT counts as a result. pe_ready outside WAIT is ignored.

Optional Feature:
- Macro: PE_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - If it reaches TIMEOUT without pe_ready: set err (sticky until reset), drop pe_start, go to DONE with the last captured res_data.
- Undefined: no counter is built; WAIT holds indefinitely and err is tied to 0.

Test Plan:
- Push 3 pairs (0x3C00,0x4000), (0x4000,0x4000), (0x3800,0x4000); go with len=3; element model returns P=0x4000, 0x4600, 0x4700 -> three pe_start windows, one 1-cycle gap between each; res_valid with res_data=0x4700; busy falls on handshake.
- go with len=0 -> no pe_start, no pe_clear; res_valid with res_data=0x0000.
- go with len=2 and FIFO empty; push one pair at cycle 5 and one at cycle 20 -> pe_start only after each push; result = second P.
- Push 9 pairs with DEPTH=8 -> full=1 after the 8th; 9th dropped; a simultaneous push/pop at full keeps count=8.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid and res_data stable; go ignored; IDLE only after res_ready=1.
- With PE_SEQ_TIMEOUT_EN and TIMEOUT=64, element never asserts pe_ready -> err=1 at cycle 64 of WAIT, DONE entered; reset asserted mid-job in a second run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pe_operand_sequencer.sv
// pe_operand_sequencer: FIFO-buffered FP16 operand issuer for one MAC element, returns the final P.
// Optional WAIT watchdog enabled by defining PE_SEQ_TIMEOUT_EN.
module pe_operand_sequencer #(
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [15:0]      wr_a,
    input  logic [15:0]      wr_b,
    output logic             full,
    input  logic             go,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             pe_clear,
    output logic             pe_start,
    output logic [15:0]      pe_a,
    output logic [15:0]      pe_b,
    input  logic             pe_ready,
    input  logic [15:0]      pe_P,
    output logic             res_valid,
    output logic [15:0]      res_data,
    input  logic             res_ready,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, GAP = 3'd3, DONE = 3'd4;

    logic [2:0]       state;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic [LEN_W-1:0] remaining;
    logic             pop, push, expired;

    assign full = cnt == (AW+1)'(DEPTH);
    assign pop  = state == ISSUE && cnt != '0;
    // a pop in the same cycle frees the slot, so a push at full is still accepted
    assign push = wr_en && (!full || pop);
    assign busy = state != IDLE;

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;
    logic          err_r;
    assign expired = state == WAIT && !pe_ready && wcnt == TW'(TIMEOUT - 1);
    assign err = err_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt  <= '0;
            err_r <= 1'b0;
        end else begin
            wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
            if (expired) err_r <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {wr_a, wr_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            remaining <= '0;
            pe_clear  <= 1'b0;
            pe_start  <= 1'b0;
            pe_a      <= '0;
            pe_b      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            pe_clear <= 1'b0;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            case (state)
                IDLE: if (go) begin
                    res_data <= '0;
                    if (len != '0) begin
                        remaining <= len;
                        pe_clear  <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                ISSUE: if (pop) begin
                    {pe_a, pe_b} <= mem[rp];
                    pe_start     <= 1'b1;
                    state        <= WAIT;
                end
                WAIT: if (pe_ready) begin
                    res_data  <= pe_P;
                    remaining <= remaining - 1'b1;
                    pe_start  <= 1'b0;
                    res_valid <= remaining == LEN_W'(1);
                    state     <= remaining == LEN_W'(1) ? DONE : GAP;
                end else if (expired) begin
                    pe_start  <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                GAP: state <= ISSUE;
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_operand_sequencer.sv
// tb_pe_operand_sequencer: directed checks of the operand sequencer against a fixed-latency element model.
`timescale 1ns/1ps
module tb_pe_operand_sequencer;
    logic        clk = 1'b0;
    logic        reset, wr_en, go, pe_ready, res_ready, model_en;
    logic [15:0] wr_a, wr_b, pe_P, pe_a, pe_b, res_data;
    logic [3:0]  len;
    logic        full, busy, pe_clear, pe_start, res_valid, err;
    logic [15:0] p_tab [16];
    int          p_idx = 0, lat = 0;
    int          n_chk = 0, n_pass = 0;

    pe_operand_sequencer #(.DEPTH(8), .LEN_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .full(full),
        .go(go), .len(len), .busy(busy), .pe_clear(pe_clear), .pe_start(pe_start),
        .pe_a(pe_a), .pe_b(pe_b), .pe_ready(pe_ready), .pe_P(pe_P),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .err(err)
    );

    always #5 clk = ~clk;

    // element model: pulses pe_ready on the third cycle pe_start is seen high
    initial begin
        pe_ready = 1'b0;
        pe_P = '0;
        forever begin
            @(negedge clk);
            if (pe_ready || !pe_start || !model_en) begin
                pe_ready = 1'b0;
                lat = 0;
            end else if (lat == 2) begin
                pe_ready = 1'b1;
                pe_P = p_tab[p_idx];
                p_idx++;
                lat = 0;
            end else lat++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        wr_en = 1'b1;
        wr_a = a;
        wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // go at cycle 0, optional pushes at cycles p1/p2, observe until res_valid or cap cycles
    task automatic run_job(input int len_v, input int p1, input int p2, input int cap,
                           output int starts, output int clears, output int gmin, output int gmax,
                           output int r1, output int r2, output int hi,
                           output logic [15:0] fa, output logic [15:0] la);
        int   gap;
        logic prev;
        starts = 0; clears = 0; gmin = 999; gmax = 0; r1 = -1; r2 = -1; hi = 0;
        fa = '0; la = '0; gap = 0; prev = 1'b0;
        for (int i = 0; i < cap && !res_valid; i++) begin
            if (pe_clear) clears++;
            if (pe_start) hi++;
            if (pe_start && !prev) begin
                if (starts > 0) begin
                    gmin = gap < gmin ? gap : gmin;
                    gmax = gap > gmax ? gap : gmax;
                end else begin
                    r1 = i;
                    fa = pe_a;
                end
                r2 = i;
                la = pe_a;
                starts++;
            end
            gap = pe_start ? 0 : gap + 1;
            prev = pe_start;
            go = i == 0;
            len = len_v[3:0];
            wr_en = i == p1 || i == p2;
            wr_a = 16'h3C00 + i[15:0];
            wr_b = 16'h4000;
            @(negedge clk);
        end
        go = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int s, c, gmn, gmx, r1, r2, hi;
        logic [15:0] fa, la;
        logic ok;
        p_tab = '{16'h4000, 16'h4600, 16'h4700, 16'h4200, 16'h4400, 16'h1111,
                  16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005, 16'h5006,
                  16'h5007, 16'h5008, 16'h0000, 16'h0000};
        model_en = 1'b1; reset = 1'b1; wr_en = 1'b0; go = 1'b0; len = '0;
        wr_a = '0; wr_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({full, busy, pe_clear, pe_start, res_valid, err}), 32'h0);
        check("reset_operands", {pe_a, pe_b}, 32'h0);
        check("reset_res_data", 32'(res_data), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // three-pair dot product
        push(16'h3C00, 16'h4000);
        push(16'h4000, 16'h4000);
        push(16'h3800, 16'h4000);
        run_job(3, -1, -1, 200, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t1_starts", 32'(s), 32'd3);
        check("t1_clears", 32'(c), 32'd1);
        check("t1_gap_min_ge1", 32'(gmn >= 1), 32'd1);
        check("t1_gap_max_le2", 32'(gmx <= 2), 32'd1);
        check("t1_start_cycles", 32'(hi), 32'd9);
        check("t1_first_a", 32'(fa), 32'h3C00);
        check("t1_last_a", 32'(la), 32'h3800);
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'h4700);
        check("t1_err", 32'(err), 32'd0);

        // result held under backpressure, go ignored in DONE
        ok = 1'b1;
        go = 1'b1;
        len = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok = ok && res_valid && res_data == 16'h4700 && busy && !pe_start && !pe_clear;
        end
        go = 1'b0;
        check("t5_hold_stable", 32'(ok), 32'd1);
        handshake;
        check("t5_release", 32'({res_valid, busy}), 32'h0);
        @(negedge clk);
        check("t5_idle_stays", 32'({busy, pe_clear, pe_start}), 32'h0);

        // zero-length job
        run_job(0, -1, -1, 20, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t2_starts", 32'(s), 32'd0);
        check("t2_clears", 32'(c), 32'd0);
        check("t2_valid", 32'(res_valid), 32'd1);
        check("t2_data", 32'(res_data), 32'h0);
        handshake;
        check("t2_idle", 32'(busy), 32'd0);

        // job started on an empty FIFO, pairs trickle in
        run_job(2, 5, 20, 200, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t3_starts", 32'(s), 32'd2);
        check("t3_first_after_push", 32'(r1 > 5), 32'd1);
        check("t3_second_after_push", 32'(r2 > 20), 32'd1);
        check("t3_first_a", 32'(fa), 32'h3C05);
        check("t3_last_a", 32'(la), 32'h3C14);
        check("t3_data", 32'(res_data), 32'h4400);
        handshake;

        // fill, overflow drop, push+pop at full
        for (int i = 0; i < 8; i++) begin
            push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
            if (i == 6) check("t4_not_full_at_7", 32'(full), 32'd0);
        end
        check("t4_full_at_8", 32'(full), 32'd1);
        push(16'h9999, 16'h9999);
        check("t4_full_after_drop", 32'(full), 32'd1);
        run_job(1, 1, -1, 100, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t4_pop_a", 32'(fa), 32'h1000);
        check("t4_pop_data", 32'(res_data), 32'h1111);
        check("t4_full_after_pushpop", 32'(full), 32'd1);
        handshake;
        run_job(8, -1, -1, 400, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t4_drain_starts", 32'(s), 32'd8);
        check("t4_drain_first_a", 32'(fa), 32'h1001);
        check("t4_drain_last_a", 32'(la), 32'h3C01);
        check("t4_drain_data", 32'(res_data), 32'h5008);
        handshake;
        check("t4_empty_not_full", 32'(full), 32'd0);

`ifdef PE_SEQ_TIMEOUT_EN
        // silent element trips the watchdog
        model_en = 1'b0;
        push(16'h3C00, 16'h3C00);
        run_job(1, -1, -1, 300, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t7_start_cycles", 32'(hi), 32'd64);
        check("t7_err", 32'(err), 32'd1);
        check("t7_valid", 32'(res_valid), 32'd1);
        check("t7_data", 32'(res_data), 32'h0);
        handshake;
        check("t7_err_sticky", 32'(err), 32'd1);
        model_en = 1'b1;
`endif

        // reset mid-job aborts and discards buffered pairs
        push(16'h7000, 16'h7000);
        push(16'h7001, 16'h7001);
        go = 1'b1;
        len = 4'd2;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_mid_job", 32'({busy, pe_start}), 32'h3);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_flags", 32'({full, busy, pe_clear, pe_start, res_valid, err}), 32'h0);
        check("t6_reset_operands", {pe_a, pe_b}, 32'h0);
        check("t6_reset_res_data", 32'(res_data), 32'h0);
        reset = 1'b0;
        run_job(1, -1, -1, 20, s, c, gmn, gmx, r1, r2, hi, fa, la);
        check("t6_fifo_discarded", 32'(s), 32'd0);
        check("t6_stalled", 32'({busy, res_valid}), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
